// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/redirect sequencing for the 5-stage RV32 pipeline.
// Tracks three situations: normal flow (RUN), a multi-cycle MUL/DIV holding
// EX (MDBUSY), and a taken branch whose redirect waits on an outstanding
// instruction fetch (REDIR). Every control output is combinational from the
// registered state plus the current inputs, and is forced low during reset.
module hazard_ctrl #(
    parameter int XLEN       = 32,
    parameter int MD_LATENCY = 34,
    parameter int CNT_W      = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [4:0]      Rs1D,
    input  logic [4:0]      Rs2D,
    input  logic [4:0]      RdE,
    input  logic            ResultSrcE0,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            md_startE,
    input  logic            imem_valid,
    output logic            StallF,
    output logic            StallD,
    output logic            StallE,
    output logic            FlushD,
    output logic            FlushE,
    output logic            FlushM,
    output logic            PCSelF,
    output logic [XLEN-1:0] PCRedirF,
    output logic            md_doneE,
    output logic [1:0]      fsm_state
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        MDBUSY = 2'd1,
        REDIR  = 2'd2
    } state_t;

    // A single-cycle MUL/DIV never leaves RUN; longer ops preload the counter
    // so that it reaches zero on the final (result) cycle of EX occupancy.
    localparam bit              MD_MULTI   = (MD_LATENCY > 1);
    localparam int              CNT_LOAD_I = (MD_LATENCY > 1) ? (MD_LATENCY - 2) : 0;
    localparam logic [CNT_W-1:0] CNT_LOAD  = CNT_LOAD_I[CNT_W-1:0];

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [XLEN-1:0]   tgt;
    logic              lw_stall;

    assign fsm_state = state;

    // Load in EX writing a register the instruction in ID reads (x0 never hazards).
    assign lw_stall = ResultSrcE0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));

    // State, MUL/DIV countdown and deferred redirect target.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            cnt   <= '0;
            tgt   <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (PCSrcE) begin
                        if (!imem_valid) begin
                            tgt   <= PCTargetE;
                            state <= REDIR;
                        end
                    end else if (md_startE && MD_MULTI) begin
                        cnt   <= CNT_LOAD;
                        state <= MDBUSY;
                    end
                end
                MDBUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state <= RUN;
                    end
                end
                REDIR: begin
                    if (imem_valid) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    // Control outputs; PCSrcE outranks md_startE, which outranks load-use and fetch waits.
    always_comb begin
        StallF   = 1'b0;
        StallD   = 1'b0;
        StallE   = 1'b0;
        FlushD   = 1'b0;
        FlushE   = 1'b0;
        FlushM   = 1'b0;
        PCSelF   = 1'b0;
        PCRedirF = '0;
        md_doneE = 1'b0;
        if (!reset) begin
            case (state)
                RUN: begin
                    PCRedirF = PCTargetE;
                    if (PCSrcE && imem_valid) begin
                        PCSelF = 1'b1;
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (PCSrcE) begin
                        // Fetch still busy: squash the wrong path and redirect later.
                        StallF = 1'b1;
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (md_startE && MD_MULTI) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end else if (md_startE) begin
                        md_doneE = 1'b1;
                    end else if (lw_stall) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end else if (!imem_valid) begin
                        // IF/ID must stay enabled so the clear actually lands.
                        StallF = 1'b1;
                        FlushD = 1'b1;
                    end
                end
                MDBUSY: begin
                    if (cnt != '0) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end else begin
                        md_doneE = 1'b1;
                    end
                end
                REDIR: begin
                    PCRedirF = tgt;
                    FlushD   = 1'b1;
                    if (imem_valid) begin
                        PCSelF = 1'b1;
                    end else begin
                        StallF = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
